ps2_host_tx: RTL

Host-to-device PS/2 transmitter: sends one command byte, e.g. 0xED (LEDs) or 0xF4 (enable), to a keyboard or mouse. It uses the standard request-to-send sequence, with the device supplying the clock. It sits beside the PS/2 serial receiver on the same two open-drain lines. It raises `busy` so the receiver's enable can be gated off while the host owns the bus.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_sync_edge.sv | 44 ++++
 rtl/ps2_host_tx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter and receiver.
//   ps2_state_t          - host transmit FSM states
//   PS2_INHIBIT_CYCLES   - default clock-inhibit length (100 us @ 50 MHz)
//   PS2_TIMEOUT_CYCLES   - default max gap between device clock falls (15 ms @ 50 MHz)
//   PS2_FRAME_BITS       - bits presented by the host after the start bit
//   ps2_odd_parity       - odd parity of a byte
//   ps2_frame_bit        - bit k of the post-start frame (data LSB first, parity, stop)
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_t;

  localparam int PS2_INHIBIT_CYCLES = 5000;
  localparam int PS2_TIMEOUT_CYCLES = 750000;
  localparam int PS2_FRAME_BITS     = 10;

  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // k 0..7 data (LSB first), k 8 parity, k 9 stop (always 1).
  function automatic logic ps2_frame_bit(input logic [7:0] b, input logic par,
                                         input logic [3:0] k);
    if (k < 4'd8) begin
      return b[k[2:0]];
    end else if (k == 4'd8) begin
      return par;
    end else begin
      return 1'b1;
    end
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizer for the PS/2 clock and data pins plus a
// falling-edge detector on the synchronized clock.
//   clk, reset     - system clock, synchronous active-high reset
//   ps2_clk_in     - raw PS/2 clock pin (asynchronous)
//   ps2_data_in    - raw PS/2 data pin (asynchronous)
//   clk_sync       - synchronized PS/2 clock
//   data_sync      - synchronized PS/2 data
//   fall           - one-cycle pulse when clk_sync goes 1->0
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic fall
);

  logic clk_s1, clk_s2, clk_s3;
  logic data_s1, data_s2;

  // Idle PS/2 lines are high, so the flops reset to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

  assign clk_sync  = clk_s2;
  assign data_sync = data_s2;
  // Combinational so that the consumer's register adds the third cycle.
  assign fall      = clk_s3 & ~clk_s2;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter (request-to-send sequence).
//   clk, reset   - system clock, synchronous active-high reset
//   tx_data      - command byte, sampled on tx_valid & tx_ready
//   tx_valid     - request to send
//   tx_ready     - high only in IDLE (decoded from state)
//   ps2_clk_in   - raw PS/2 clock pin
//   ps2_data_in  - raw PS/2 data pin
//   ps2_clk_oe   - 1 pulls the PS/2 clock low
//   ps2_data_oe  - 1 pulls the PS/2 data low
//   busy         - high in every state except IDLE
//   done         - one-cycle pulse on device ACK
//   err          - one-cycle pulse on NACK or watchdog timeout
//   dbg_state    - current FSM state
//
// Handshake: a byte transfers on a rising clk edge where tx_valid and
// tx_ready are both high; tx_valid while tx_ready is low is dropped, not queued.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  // One counter serves both the inhibit delay and the watchdog.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  ps2_state_t state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [3:0] bit_q, bit_n;
  logic [7:0] byte_q, byte_n;
  logic par_q, par_n;

  logic clk_oe_n, data_oe_n, busy_n, done_n, err_n;

  logic clk_sync, data_sync, fall;
  logic accept, inhibit_end, in_watch, line_idle, idle_ok, wd_expire, nack;

  ps2_sync_edge u_sync (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .fall        (fall)
  );

  assign tx_ready    = (state_q == IDLE);
  assign dbg_state   = state_q;
  assign accept      = tx_valid & tx_ready;
  assign inhibit_end = (state_q == INHIBIT) && (cnt_q == CNT_W'(INHIBIT_CYCLES - 1));
  assign in_watch    = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);
  assign line_idle   = clk_sync & data_sync;
  assign idle_ok     = (state_q == WAIT_IDLE) && line_idle;
  // A fall reloads the watchdog and an idle bus completes the frame, so
  // either one overrides an expiry in the same cycle; done and err stay exclusive.
  assign wd_expire   = in_watch && !fall && !idle_ok &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign nack        = (state_q == ACK) && fall && data_sync;

  // State register (plus datapath and registered outputs)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      par_q       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      bit_q       <= bit_n;
      byte_q      <= byte_n;
      par_q       <= par_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + CNT_W'(1);
    bit_n   = bit_q;
    byte_n  = byte_q;
    par_n   = par_q;
    unique case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (accept) begin
          byte_n  = tx_data;
          par_n   = ps2_odd_parity(tx_data);
          bit_n   = '0;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inhibit_end) begin
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = SEND;
      end
      SEND: begin
        if (fall) begin
          cnt_n = '0;
          bit_n = bit_q + 4'd1;
          if (bit_q == 4'(PS2_FRAME_BITS - 1)) begin
            state_n = ACK;
          end
        end else if (wd_expire) begin
          state_n = IDLE;
        end
      end
      ACK: begin
        if (fall) begin
          cnt_n   = '0;
          state_n = data_sync ? IDLE : WAIT_IDLE;
        end else if (wd_expire) begin
          state_n = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (line_idle) begin
          state_n = IDLE;
        end else if (fall) begin
          cnt_n = '0;
        end else if (wd_expire) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Output decode; values are registered in the state-register block.
  always_comb begin
    clk_oe_n  = (state_n == INHIBIT) || (state_n == START);
    busy_n    = (state_n != IDLE);
    done_n    = idle_ok;
    err_n     = nack || wd_expire;
    data_oe_n = 1'b0;
    unique case (state_n)
      START: data_oe_n = 1'b1;
      // Start bit stays driven until the first fall; each fall presents bit k.
      SEND:  data_oe_n = (state_q == SEND && fall) ? ~ps2_frame_bit(byte_q, par_q, bit_q)
                                                   : ps2_data_oe;
      default: data_oe_n = 1'b0;
    endcase
  end

endmodule
